// File: rtl/rotate_mask_unit.sv
// Pipelined SPU right rotate-and-mask unit: rotm, rotma, rothm, rotmah and their RI7 forms.
// Optional macro ROTATE_MASK_OP_COUNT_EN adds op_count, a saturating count of retired writes.
module rotate_mask_unit #(
   parameter int unsigned WIDTH  = 128,
   parameter int unsigned STAGES = 4,
   parameter int unsigned ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [0:31]       instruction,
   input  logic [0:WIDTH-1]  RA_data_in,
   input  logic [0:WIDTH-1]  RB_data_in,
   input  logic [0:ADDR_W-1] RT_addr_in,
   output logic              out_valid,
   output logic              write_en,
   output logic [0:WIDTH-1]  RT_data_out,
   output logic [0:ADDR_W-1] RT_addr_out
`ifdef ROTATE_MASK_OP_COUNT_EN
   ,
   output logic [0:31]       op_count
`endif
);

   localparam int unsigned NW = WIDTH / 32;
   localparam int unsigned NH = WIDTH / 16;
   localparam int unsigned ND = STAGES - 1;   // registers for stages 2..STAGES

   logic                  dec_legal, dec_half, dec_arith, dec_imm;
   logic [NW-1:0][5:0]    wcnt_d;
   logic [NH-1:0][4:0]    hcnt_d;

   logic                  s1_valid, s1_legal, s1_half, s1_arith;
   logic [NW-1:0][5:0]    s1_wcnt;
   logic [NH-1:0][4:0]    s1_hcnt;
   logic [0:WIDTH-1]      s1_ra;
   logic [0:ADDR_W-1]     s1_addr;

   logic [0:WIDTH-1]      res_c;
   logic [ND-1:0]         valid_d, wen_d, p_valid, p_wen;
   logic [ND-1:0][0:WIDTH-1]  p_data;
   logic [ND-1:0][0:ADDR_W-1] p_addr;

   // Register-field and upper count bits that never affect the result.
   logic unused_bits;
   assign unused_bits = ^{instruction[11], instruction[18:31], RB_data_in};

   function automatic logic [31:0] shr32(input logic [31:0] v, input logic [5:0] c,
                                         input logic arith);
      if (c[5]) return {32{arith & v[31]}};
      if (arith) return 32'($signed(v) >>> c[4:0]);
      return v >> c[4:0];
   endfunction

   function automatic logic [15:0] shr16(input logic [15:0] v, input logic [4:0] c,
                                         input logic arith);
      if (c[4]) return {16{arith & v[15]}};
      if (arith) return 16'($signed(v) >>> c[3:0]);
      return v >> c[3:0];
   endfunction

   // Opcode decode.
   always_comb begin
      dec_legal = 1'b1;
      dec_half  = 1'b0;
      dec_arith = 1'b0;
      dec_imm   = 1'b0;
      case (instruction[0:10])
         11'b00001011001: begin end
         11'b00001011010: dec_arith = 1'b1;
         11'b00001011101: dec_half  = 1'b1;
         11'b00001011110: begin dec_half = 1'b1; dec_arith = 1'b1; end
         11'b00001111001: dec_imm   = 1'b1;
         11'b00001111010: begin dec_imm = 1'b1; dec_arith = 1'b1; end
         11'b00001111101: begin dec_imm = 1'b1; dec_half = 1'b1; end
         11'b00001111110: begin dec_imm = 1'b1; dec_half = 1'b1; dec_arith = 1'b1; end
         default:         dec_legal = 1'b0;
      endcase
   end

   // Shift counts are the negated source; only the low bits of sext(I7) matter.
   always_comb begin
      wcnt_d = '0;
      hcnt_d = '0;
      for (int j = 0; j < NW; j++)
         wcnt_d[j] = 6'd0 - (dec_imm ? instruction[12:17] : RB_data_in[32*j+26 +: 6]);
      for (int h = 0; h < NH; h++)
         hcnt_d[h] = 5'd0 - (dec_imm ? instruction[13:17] : RB_data_in[16*h+11 +: 5]);
   end

   // Stage-2 compute from the stage-1 registers.
   always_comb begin
      res_c = '0;
      if (s1_legal) begin
         if (s1_half) begin
            for (int h = 0; h < NH; h++)
               res_c[16*h +: 16] = shr16(s1_ra[16*h +: 16], s1_hcnt[h], s1_arith);
         end else begin
            for (int j = 0; j < NW; j++)
               res_c[32*j +: 32] = shr32(s1_ra[32*j +: 32], s1_wcnt[j], s1_arith);
         end
      end
   end

   always_comb begin
      valid_d    = '0;
      wen_d      = '0;
      valid_d[0] = s1_valid & ~flush;
      wen_d[0]   = s1_valid & s1_legal & ~flush;
      for (int k = 1; k < ND; k++) begin
         valid_d[k] = p_valid[k-1] & ~flush;
         wen_d[k]   = p_wen[k-1] & ~flush;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_legal <= 1'b0;
         s1_half  <= 1'b0;
         s1_arith <= 1'b0;
         s1_wcnt  <= '0;
         s1_hcnt  <= '0;
         s1_ra    <= '0;
         s1_addr  <= '0;
         p_valid  <= '0;
         p_wen    <= '0;
         p_data   <= '0;
         p_addr   <= '0;
      end else begin
         s1_valid  <= in_valid & ~flush;
         s1_legal  <= dec_legal;
         s1_half   <= dec_half;
         s1_arith  <= dec_arith;
         s1_wcnt   <= wcnt_d;
         s1_hcnt   <= hcnt_d;
         s1_ra     <= RA_data_in;
         s1_addr   <= RT_addr_in;
         p_valid   <= valid_d;
         p_wen     <= wen_d;
         p_data[0] <= res_c;
         p_addr[0] <= s1_addr;
         for (int k = 1; k < ND; k++) begin
            p_data[k] <= p_data[k-1];
            p_addr[k] <= p_addr[k-1];
         end
      end
   end

   assign out_valid   = p_valid[ND-1];
   assign write_en    = p_wen[ND-1];
   assign RT_data_out = p_data[ND-1];
   assign RT_addr_out = p_addr[ND-1];

`ifdef ROTATE_MASK_OP_COUNT_EN
   // Counts on the edge a writing op enters the output stage, so flushed ops never count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         op_count <= '0;
      else if (wen_d[ND-1] && op_count != 32'hFFFF_FFFF)
         op_count <= op_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_rotate_mask_unit.sv
// Self-checking bench for rotate_mask_unit: scoreboard queue filled at issue, drained at retire.
module tb_rotate_mask_unit;
   localparam int STAGES = 4;

   localparam logic [10:0] OP_ROTM    = 11'b00001011001;
   localparam logic [10:0] OP_ROTMA   = 11'b00001011010;
   localparam logic [10:0] OP_ROTHM   = 11'b00001011101;
   localparam logic [10:0] OP_ROTMAH  = 11'b00001011110;
   localparam logic [10:0] OP_ROTMI   = 11'b00001111001;
   localparam logic [10:0] OP_ROTMAI  = 11'b00001111010;
   localparam logic [10:0] OP_ROTHMI  = 11'b00001111101;
   localparam logic [10:0] OP_ROTMAHI = 11'b00001111110;
   localparam logic [10:0] OPS [8] = '{OP_ROTM, OP_ROTMA, OP_ROTHM, OP_ROTMAH,
                                       OP_ROTMI, OP_ROTMAI, OP_ROTHMI, OP_ROTMAHI};

   typedef struct {
      logic [6:0]   addr;
      logic [127:0] data;
      logic         we;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
   logic [31:0]  instruction = '0;
   logic [127:0] RA_data_in = '0, RB_data_in = '0, RT_data_out;
   logic [6:0]   RT_addr_in = '0, RT_addr_out;
   logic         out_valid, write_en;
`ifdef ROTATE_MASK_OP_COUNT_EN
   logic [31:0]  op_count;
`endif

   exp_t exq[$];
   int errors = 0, checks = 0, cyc = 0, exp_ops = 0;

   rotate_mask_unit #(.WIDTH(128), .STAGES(STAGES), .ADDR_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .instruction(instruction), .RA_data_in(RA_data_in), .RB_data_in(RB_data_in),
      .RT_addr_in(RT_addr_in), .out_valid(out_valid), .write_en(write_en),
      .RT_data_out(RT_data_out), .RT_addr_out(RT_addr_out)
`ifdef ROTATE_MASK_OP_COUNT_EN
      , .op_count(op_count)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: 64-bit shifts absorb counts beyond the slot width.
   function automatic logic [128:0] model(input logic [31:0] ins, input logic [127:0] ra,
                                          input logic [127:0] rb);
      logic [127:0] r;
      int i7, cnt;
      longint src, w;
      bit half, arith, imm;
      r = '0; half = 0; arith = 0; imm = 0;
      i7 = int'(ins[20:14]);
      if (i7 > 63) i7 = i7 - 128;
      case (ins[31:21])
         OP_ROTM:    begin end
         OP_ROTMA:   arith = 1;
         OP_ROTHM:   half = 1;
         OP_ROTMAH:  begin half = 1; arith = 1; end
         OP_ROTMI:   imm = 1;
         OP_ROTMAI:  begin imm = 1; arith = 1; end
         OP_ROTHMI:  begin imm = 1; half = 1; end
         OP_ROTMAHI: begin imm = 1; half = 1; arith = 1; end
         default:    return {1'b0, 128'd0};
      endcase
      if (!half) begin
         for (int j = 0; j < 4; j++) begin
            src = imm ? longint'(i7) : longint'($signed(rb[127-32*j -: 32]));
            cnt = int'((0 - src) & 63);
            w = arith ? longint'($signed(ra[127-32*j -: 32])) : longint'(ra[127-32*j -: 32]);
            w = w >>> cnt;
            r[127-32*j -: 32] = w[31:0];
         end
      end else begin
         for (int h = 0; h < 8; h++) begin
            src = imm ? longint'(i7) : longint'($signed(rb[127-16*h -: 16]));
            cnt = int'((0 - src) & 31);
            w = arith ? longint'($signed(ra[127-16*h -: 16])) : longint'(ra[127-16*h -: 16]);
            w = w >>> cnt;
            r[127-16*h -: 16] = w[15:0];
         end
      end
      return {1'b1, r};
   endfunction

   function automatic logic [31:0] mk(input logic [10:0] op, input logic [6:0] i7);
      return {op, i7, 14'($urandom)};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic send(input logic [31:0] ins, input logic [127:0] ra, input logic [127:0] rb,
                       input logic [6:0] addr, input logic fl, input logic push,
                       input logic we, input logic [127:0] data);
      exp_t e;
      @(negedge clk);
      instruction = ins; RA_data_in = ra; RB_data_in = rb; RT_addr_in = addr;
      flush = fl; in_valid = 1'b1;
      if (push) begin
         e.addr = addr; e.data = data; e.we = we; e.cyc = cyc + STAGES;
         exq.push_back(e);
      end
   endtask

   task automatic sendm(input logic [31:0] ins, input logic [127:0] ra, input logic [127:0] rb,
                        input logic [6:0] addr);
      logic [128:0] m;
      m = model(ins, ra, rb);
      send(ins, ra, rb, addr, 1'b0, 1'b1, m[128], m[127:0]);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, write_en, RT_data_out, RT_addr_out} !== '0) begin
         errors++;
         $display("FAIL reset_state: got v=%b we=%b data=%h addr=%0d, expected all zero",
                  out_valid, write_en, RT_data_out, RT_addr_out);
      end
`ifdef ROTATE_MASK_OP_COUNT_EN
      checks++;
      if (op_count !== 32'd0) begin
         errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_rotm();
      int got = 0; exp_t e;
      fork
         begin
            send(mk(OP_ROTM, 7'h00), {4{32'h80000001}},
                 {32'hFFFFFFFF, 32'hFFFFFFE0, 32'h00000000, 32'hFFFFFFC0}, 7'd5, 1'b0, 1'b1, 1'b1,
                 {32'h40000000, 32'h00000000, 32'h80000001, 32'h80000001});
            idle();
         end
         for (int c = 0; c < 1 + STAGES + 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
               checks++;
               if (exq.size() == 0) begin
                  errors++; $display("FAIL rotm: unexpected out_valid addr=%0d", RT_addr_out);
               end else begin
                  e = exq.pop_front(); got++;
                  if (write_en !== e.we || RT_addr_out !== e.addr || RT_data_out !== e.data || cyc != e.cyc) begin
                     errors++;
                     $display("FAIL rotm: got we=%b addr=%0d data=%h cyc=%0d, expected we=%b addr=%0d data=%h cyc=%0d",
                              write_en, RT_addr_out, RT_data_out, cyc, e.we, e.addr, e.data, e.cyc);
                  end
                  if (e.we) exp_ops++;
               end
            end
         end
      join
      checks++;
      if (got != 1) begin errors++; $display("FAIL rotm_count: got %0d results expected 1", got); end
   endtask

   task automatic test_rotmai();
      int got = 0; exp_t e;
      logic [127:0] ra;
      ra = {32'hF0000000, 32'h70000000, 32'h80000000, 32'h12345678};
      fork
         begin
            send(mk(OP_ROTMAI, 7'h7C), ra, rnd128(), 7'd10, 1'b0, 1'b1, 1'b1,
                 {32'hFF000000, 32'h07000000, 32'hF8000000, 32'h01234567});
            send(mk(OP_ROTMAI, 7'h40), ra, rnd128(), 7'd11, 1'b0, 1'b1, 1'b1, ra);
            idle();
         end
         for (int c = 0; c < 2 + STAGES + 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
               checks++;
               if (exq.size() == 0) begin
                  errors++; $display("FAIL rotmai: unexpected out_valid addr=%0d", RT_addr_out);
               end else begin
                  e = exq.pop_front(); got++;
                  if (write_en !== e.we || RT_addr_out !== e.addr || RT_data_out !== e.data || cyc != e.cyc) begin
                     errors++;
                     $display("FAIL rotmai: got we=%b addr=%0d data=%h cyc=%0d, expected we=%b addr=%0d data=%h cyc=%0d",
                              write_en, RT_addr_out, RT_data_out, cyc, e.we, e.addr, e.data, e.cyc);
                  end
                  if (e.we) exp_ops++;
               end
            end
         end
      join
      checks++;
      if (got != 2) begin errors++; $display("FAIL rotmai_count: got %0d results expected 2", got); end
   endtask

   task automatic test_halfword();
      int got = 0; exp_t e;
      fork
         begin
            send(mk(OP_ROTHM, 7'h00), {8{16'h8000}}, {4{16'hFFFF, 16'hFFF0}}, 7'd12,
                 1'b0, 1'b1, 1'b1, {4{16'h4000, 16'h0000}});
            send(mk(OP_ROTMAH, 7'h00), {8{16'h8000}}, {4{16'hFFFF, 16'hFFF0}}, 7'd13,
                 1'b0, 1'b1, 1'b1, {4{16'hC000, 16'hFFFF}});
            idle();
         end
         for (int c = 0; c < 2 + STAGES + 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
               checks++;
               if (exq.size() == 0) begin
                  errors++; $display("FAIL halfword: unexpected out_valid addr=%0d", RT_addr_out);
               end else begin
                  e = exq.pop_front(); got++;
                  if (write_en !== e.we || RT_addr_out !== e.addr || RT_data_out !== e.data || cyc != e.cyc) begin
                     errors++;
                     $display("FAIL halfword: got we=%b addr=%0d data=%h cyc=%0d, expected we=%b addr=%0d data=%h cyc=%0d",
                              write_en, RT_addr_out, RT_data_out, cyc, e.we, e.addr, e.data, e.cyc);
                  end
                  if (e.we) exp_ops++;
               end
            end
         end
      join
      checks++;
      if (got != 2) begin errors++; $display("FAIL halfword_count: got %0d results expected 2", got); end
   endtask

   task automatic test_back_to_back(input int n, input bit with_illegal);
      int got = 0; exp_t e;
      logic [10:0] op;
      fork
         begin
            for (int k = 0; k < n; k++) begin
               op = (with_illegal && (k % 5 == 4)) ? 11'h000 : OPS[k % 8];
               sendm(mk(op, 7'($urandom)), rnd128(), rnd128(), 7'(k + 1));
            end
            idle();
         end
         for (int c = 0; c < n + STAGES + 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
               checks++;
               if (exq.size() == 0) begin
                  errors++; $display("FAIL back_to_back: unexpected out_valid addr=%0d", RT_addr_out);
               end else begin
                  e = exq.pop_front(); got++;
                  if (write_en !== e.we || RT_addr_out !== e.addr || RT_data_out !== e.data || cyc != e.cyc) begin
                     errors++;
                     $display("FAIL back_to_back: got we=%b addr=%0d data=%h cyc=%0d, expected we=%b addr=%0d data=%h cyc=%0d",
                              write_en, RT_addr_out, RT_data_out, cyc, e.we, e.addr, e.data, e.cyc);
                  end
                  if (e.we) exp_ops++;
               end
            end
         end
      join
      checks++;
      if (got != n) begin errors++; $display("FAIL back_to_back_count: got %0d results expected %0d", got, n); end
`ifdef ROTATE_MASK_OP_COUNT_EN
      checks++;
      if (op_count !== 32'(exp_ops)) begin
         errors++; $display("FAIL op_count_b2b: got %0d expected %0d", op_count, exp_ops);
      end
`endif
   endtask

   task automatic test_flush();
      int got = 0; exp_t e;
      fork
         begin
            send(mk(OP_ROTM, 7'h00), rnd128(), rnd128(), 7'd20, 1'b0, 1'b0, 1'b0, '0);
            send(mk(OP_ROTMI, 7'h7F), rnd128(), rnd128(), 7'd21, 1'b0, 1'b0, 1'b0, '0);
            send(mk(OP_ROTHM, 7'h00), rnd128(), rnd128(), 7'd22, 1'b1, 1'b0, 1'b0, '0);
            sendm(mk(OP_ROTMAI, 7'h7E), rnd128(), rnd128(), 7'd23);
            idle();
         end
         for (int c = 0; c < 4 + STAGES + 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
               checks++;
               if (exq.size() == 0) begin
                  errors++; $display("FAIL flush: unexpected out_valid addr=%0d", RT_addr_out);
               end else begin
                  e = exq.pop_front(); got++;
                  if (write_en !== e.we || RT_addr_out !== e.addr || RT_data_out !== e.data || cyc != e.cyc) begin
                     errors++;
                     $display("FAIL flush: got we=%b addr=%0d data=%h cyc=%0d, expected we=%b addr=%0d data=%h cyc=%0d",
                              write_en, RT_addr_out, RT_data_out, cyc, e.we, e.addr, e.data, e.cyc);
                  end
                  if (e.we) exp_ops++;
               end
            end
         end
      join
      checks++;
      if (got != 1) begin errors++; $display("FAIL flush_count: got %0d results expected 1", got); end
`ifdef ROTATE_MASK_OP_COUNT_EN
      checks++;
      if (op_count !== 32'(exp_ops)) begin
         errors++; $display("FAIL op_count_flush: got %0d expected %0d", op_count, exp_ops);
      end
`endif
   endtask

   task automatic test_illegal();
      int got = 0; exp_t e;
      fork
         begin
            send({11'b00000000000, 7'h15, 14'h2AAA}, rnd128(), rnd128(), 7'd30,
                 1'b0, 1'b1, 1'b0, 128'd0);
            idle();
         end
         for (int c = 0; c < 1 + STAGES + 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
               checks++;
               if (exq.size() == 0) begin
                  errors++; $display("FAIL illegal: unexpected out_valid addr=%0d", RT_addr_out);
               end else begin
                  e = exq.pop_front(); got++;
                  if (write_en !== e.we || RT_addr_out !== e.addr || RT_data_out !== e.data || cyc != e.cyc) begin
                     errors++;
                     $display("FAIL illegal: got we=%b addr=%0d data=%h cyc=%0d, expected we=%b addr=%0d data=%h cyc=%0d",
                              write_en, RT_addr_out, RT_data_out, cyc, e.we, e.addr, e.data, e.cyc);
                  end
                  if (e.we) exp_ops++;
               end
            end
         end
      join
      checks++;
      if (got != 1) begin errors++; $display("FAIL illegal_count: got %0d results expected 1", got); end
`ifdef ROTATE_MASK_OP_COUNT_EN
      checks++;
      if (op_count !== 32'(exp_ops)) begin
         errors++; $display("FAIL op_count_illegal: got %0d expected %0d", op_count, exp_ops);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int seen = 0, spurious = 0;
      fork
         begin
            for (int k = 0; k < 4; k++)
               sendm(mk(OP_ROTMA, 7'($urandom)), rnd128(), rnd128(), 7'(40 + k));
            idle();
         end
         begin
            for (int c = 0; c < STAGES + 6 && seen == 0; c++) begin
               @(negedge clk);
               if (out_valid) seen = 1;
            end
            rst_n = 1'b0;
            #1;
            checks++;
            if (seen == 0 || {out_valid, write_en, RT_data_out, RT_addr_out} !== '0) begin
               errors++;
               $display("FAIL reset_mid: seen=%0d v=%b we=%b data=%h addr=%0d, expected seen=1 and all zero",
                        seen, out_valid, write_en, RT_data_out, RT_addr_out);
            end
         end
      join
      exq.delete();
      exp_ops = 0;
`ifdef ROTATE_MASK_OP_COUNT_EN
      checks++;
      if (op_count !== 32'd0) begin
         errors++; $display("FAIL reset_mid_op_count: got %0d expected 0", op_count);
      end
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < STAGES + 3; c++) begin
         @(negedge clk);
         if (out_valid) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         errors++; $display("FAIL reset_mid_discard: got %0d stray results expected 0", spurious);
      end
   endtask

   initial begin
      test_reset();
      test_rotm();
      test_rotmai();
      test_halfword();
      test_back_to_back(8, 1'b0);
      test_flush();
      test_illegal();
      test_back_to_back(20, 1'b1);
      test_reset_mid();
      test_rotm();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
